// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending-machine transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_t;

  localparam logic [1:0] COIN_5   = 2'b00;
  localparam logic [1:0] COIN_10  = 2'b01;
  localparam logic [1:0] COIN_25  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] cents;
  } coin_t;

  function automatic coin_t coin_value(input logic [1:0] code);
    coin_t c;
    c.valid = 1'b1;
    case (code)
      COIN_5:  c.cents = 5'd5;
      COIN_10: c.cents = 5'd10;
      COIN_25: c.cents = 5'd25;
      default: begin
        c.cents = 5'd0;
        c.valid = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the idle-credit timeout and the dispense watchdog.
module vend_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CNT_W'(TIMEOUT_CYC);
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Fires in the last counted cycle, so the consumer acts exactly TIMEOUT_CYC edges after load.
  assign expire = en && !load && (count_reg == CNT_W'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, select/cancel arbitration,
// dispense handshake with watchdog, and unit-by-unit change payout.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int CHG_UNIT    = 5,
  parameter int MAX_CREDIT  = 60,
  parameter int CREDIT_W    = 7,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  output logic                coin_ack,
  output logic                coin_rej,
  input  logic                sel_req,
  input  logic                cancel,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                vend_done,
  output logic                err
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHG_UNIT);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic                coin_ack_next, coin_rej_next, disp_req_next, chg_req_next;
  logic                busy_next, vend_done_next, err_next;
  logic                tmr_load, tmr_en, tmr_expire;
  coin_t               coin;
  logic [CREDIT_W-1:0] coin_cents, after_vend, after_chg;
  logic                coin_fits;

  vend_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_next     = state_reg;
    credit_next    = credit;
    coin_ack_next  = 1'b0;
    coin_rej_next  = 1'b0;
    disp_req_next  = disp_req;
    chg_req_next   = chg_req;
    vend_done_next = 1'b0;
    err_next       = err;
    tmr_load       = 1'b0;
    tmr_en         = 1'b0;
    coin           = coin_value(coin_val);
    coin_cents     = CREDIT_W'(coin.cents);
    coin_fits      = coin.valid && ((credit + coin_cents) <= MAX_C);
    after_vend     = credit - PRICE_C;
    after_chg      = credit - UNIT_C;

    case (state_reg)
      ST_IDLE: begin
        if (coin_valid) begin
          tmr_load = 1'b1;
          if (coin_fits) begin
            credit_next   = credit + coin_cents;
            coin_ack_next = 1'b1;
            state_next    = ST_CREDIT;
          end else begin
            coin_rej_next = 1'b1;
          end
        end
      end

      ST_CREDIT: begin
        tmr_en = 1'b1;
        if (cancel) begin
          coin_rej_next = coin_valid;
          chg_req_next  = (credit >= UNIT_C);
          state_next    = ST_CHANGE;
        end else if (coin_valid) begin
          tmr_load = 1'b1;
          if (coin_fits) begin
            credit_next   = credit + coin_cents;
            coin_ack_next = 1'b1;
          end else begin
            coin_rej_next = 1'b1;
          end
        end else if (sel_req && (credit >= PRICE_C)) begin
          tmr_load      = 1'b1;
          disp_req_next = 1'b1;
          state_next    = ST_VEND;
        end else if (tmr_expire) begin
          chg_req_next = (credit >= UNIT_C);
          state_next   = ST_CHANGE;
        end
      end

      ST_VEND: begin
        tmr_en        = 1'b1;
        coin_rej_next = coin_valid;
        if (disp_ack) begin
          disp_req_next  = 1'b0;
          credit_next    = after_vend;
          vend_done_next = 1'b1;
          chg_req_next   = (after_vend >= UNIT_C);
          state_next     = (after_vend == '0) ? ST_IDLE : ST_CHANGE;
        end else if (tmr_expire) begin
          // Motor never acknowledged: keep the full credit for refund.
          disp_req_next = 1'b0;
          err_next      = 1'b1;
          chg_req_next  = (credit >= UNIT_C);
          state_next    = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        coin_rej_next = coin_valid;
        if (credit == '0) begin
          chg_req_next = 1'b0;
          state_next   = ST_IDLE;
        end else if (chg_req && chg_ack) begin
          credit_next  = after_chg;
          chg_req_next = (after_chg >= UNIT_C);
          if (after_chg == '0) state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next == ST_VEND) || (state_next == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      credit    <= '0;
      coin_ack  <= 1'b0;
      coin_rej  <= 1'b0;
      disp_req  <= 1'b0;
      chg_req   <= 1'b0;
      busy      <= 1'b0;
      vend_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      credit    <= credit_next;
      coin_ack  <= coin_ack_next;
      coin_rej  <= coin_rej_next;
      disp_req  <= disp_req_next;
      chg_req   <= chg_req_next;
      busy      <= busy_next;
      vend_done <= vend_done_next;
      err       <= err_next;
    end
  end

endmodule
